// File: rtl/ao486_mem_req_arbiter_pkg.sv
// Shared constants and helpers for the ao486 memory request arbiter.
package ao486_mem_req_arbiter_pkg;

  localparam int AO486_CH_WBURST = 0;
  localparam int AO486_CH_WLINE  = 1;
  localparam int AO486_CH_RBURST = 2;
  localparam int AO486_CH_RLINE  = 3;
  localparam int AO486_CH_RCODE  = 4;
  localparam int AO486_NUM_CH    = 5;

  localparam logic [2:0] GRANT_NONE = 3'd7;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  // Channel index arithmetic mod 5; callers never exceed 8.
  function automatic logic [2:0] ch_wrap(input logic [3:0] v);
    return (v >= 4'(AO486_NUM_CH)) ? 3'(v - 4'(AO486_NUM_CH)) : v[2:0];
  endfunction

  function automatic logic [AO486_NUM_CH-1:0] ch_onehot(input logic [2:0] idx);
    logic [AO486_NUM_CH-1:0] oh;
    oh = '0;
    for (int i = 0; i < AO486_NUM_CH; i++) oh[i] = (idx == 3'(i));
    return oh;
  endfunction

endpackage

// File: rtl/ao486_mem_req_arbiter_if.sv
// Request/done handshake between the ao486 core, the arbiter and the L1.5 transducer.
interface ao486_mem_req_arbiter_if;
  import ao486_mem_req_arbiter_pkg::*;

  logic [AO486_NUM_CH-1:0] up_do;
  logic [AO486_NUM_CH-1:0] up_done;
  logic                    up_code_pdone;
  logic [AO486_NUM_CH-1:0] dn_do;
  logic [AO486_NUM_CH-1:0] dn_done;
  logic                    dn_code_pdone;

  modport master (
    input  up_do, dn_done, dn_code_pdone,
    output up_done, up_code_pdone, dn_do
  );

  modport slave (
    output up_do, dn_done, dn_code_pdone,
    input  up_done, up_code_pdone, dn_do
  );
endinterface

// File: rtl/ao486_mem_req_arbiter_rr_pick.sv
// Combinational 5-way round-robin pick: first set request at or after ptr, cyclically.
module ao486_rr_pick
  import ao486_mem_req_arbiter_pkg::*;
(
  input  logic [AO486_NUM_CH-1:0] req,
  input  logic [2:0]              ptr,
  output logic                    valid,
  output logic [2:0]              idx
);

  // Walk from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = GRANT_NONE;
    for (int k = AO486_NUM_CH - 1; k >= 0; k--) begin
      if (req[ch_wrap(4'(ptr) + 4'(k))]) begin
        valid = 1'b1;
        idx   = ch_wrap(4'(ptr) + 4'(k));
      end
    end
  end

endmodule

// File: rtl/ao486_mem_req_arbiter.sv
// Serialises the five ao486 memory request channels toward the L1.5 transducer.
// Optional grant watchdog enabled by defining AO486_ARB_TIMEOUT_EN.
module ao486_mem_req_arbiter
  import ao486_mem_req_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ao486_mem_req_arbiter_if.master bus,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 err_spurious,
  output logic                 err_timeout
);

  if (GAP_CYCLES < 2) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 8192) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..8192");
  end

  localparam int GW = $clog2(GAP_CYCLES);

  arb_state_e    state_q, state_d;
  logic [2:0]    g_q, g_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_sp_q, err_sp_d;

  logic                    pick_valid;
  logic [2:0]              pick_idx;
  logic [AO486_NUM_CH-1:0] g_oh, exp_mask;
  logic                    in_grant, done_g, held, timeout_hit;

  ao486_rr_pick u_pick (
    .req   (bus.up_do),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign g_oh     = ch_onehot(g_q);
  assign in_grant = (state_q == ARB_GRANT);
  assign exp_mask = in_grant ? g_oh : '0;
  assign done_g   = |(bus.dn_done & exp_mask);
  assign held     = |(bus.up_do & g_oh);

`ifdef AO486_ARB_TIMEOUT_EN
  logic [12:0] tcnt_q, tcnt_d;
  logic        err_to_q, err_to_d;
  assign timeout_hit = in_grant && (tcnt_q == 13'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_to_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    gap_d    = gap_q;
    err_sp_d = err_sp_q | (|(bus.dn_done & ~exp_mask));
`ifdef AO486_ARB_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    err_to_d = err_to_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          g_d     = pick_idx;
          state_d = ARB_GRANT;
`ifdef AO486_ARB_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
`ifdef AO486_ARB_TIMEOUT_EN
        tcnt_d = tcnt_q + 13'd1;
`endif
        // Done wins over a same-cycle drop of up_do or watchdog expiry.
        if (done_g) begin
          rr_ptr_d = ch_wrap(4'(g_q) + 4'd1);
          state_d  = ARB_GAP;
          gap_d    = GW'(GAP_CYCLES - 1);
        end else if (!held || timeout_hit) begin
          state_d  = ARB_GAP;
          gap_d    = GW'(GAP_CYCLES - 1);
`ifdef AO486_ARB_TIMEOUT_EN
          if (held) err_to_d = 1'b1;
`endif
        end
      end
      ARB_GAP: begin
        if (gap_q == '0) state_d = ARB_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      g_q      <= '0;
      rr_ptr_q <= '0;
      gap_q    <= '0;
      err_sp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
      gap_q    <= gap_d;
      err_sp_q <= err_sp_d;
    end
  end

`ifdef AO486_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt_q   <= '0;
      err_to_q <= 1'b0;
    end else begin
      tcnt_q   <= tcnt_d;
      err_to_q <= err_to_d;
    end
  end
`endif

  assign bus.dn_do         = in_grant ? (g_oh & bus.up_do) : '0;
  assign bus.up_done       = done_g ? g_oh : '0;
  assign bus.up_code_pdone = bus.dn_code_pdone & in_grant & (g_q == 3'(AO486_CH_RCODE));
  assign busy              = (state_q != ARB_IDLE);
  assign grant_id          = in_grant ? g_q : GRANT_NONE;
  assign err_spurious      = err_sp_q;

endmodule
